// File: rtl/pcileech_ft245_pkg.sv
// pcileech_ft245_pkg: shared types and constants for the FT245 TX arbiter; state set depends on PCILEECH_FT245_TX_ARB_HDR_EN
package pcileech_ft245_pkg;
  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam logic [23:0] HDR_TAG = 24'hE0A500;
`ifdef PCILEECH_FT245_TX_ARB_HDR_EN
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DRAIN, S_HDR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DRAIN} state_t;
`endif
endpackage

// File: rtl/pcileech_ft245_tx_arb_if.sv
// pcileech_ft245_tx_arb_if: word-source and FT245 pull-side signals of the TX arbiter
interface pcileech_ft245_tx_arb_if
  import pcileech_ft245_pkg::*;
#(parameter int NUM_SRC = 4);
  logic [NUM_SRC*WORD_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC-1:0]        src_last;
  logic [NUM_SRC-1:0]        src_ready;
  logic [BYTE_W-1:0]         ft_din;
  logic                      ft_din_empty;
  logic                      ft_din_req_data;
  logic                      ft_din_wr_en;
  logic [2:0]                grant_id;
  modport master (
    input  src_data, src_valid, src_last, ft_din_req_data,
    output src_ready, ft_din, ft_din_empty, ft_din_wr_en, grant_id
  );
  modport slave (
    output src_data, src_valid, src_last, ft_din_req_data,
    input  src_ready, ft_din, ft_din_empty, ft_din_wr_en, grant_id
  );
endinterface

// File: rtl/pcileech_ft245_word2byte.sv
// pcileech_ft245_word2byte: 32-bit word to LSB-first byte serializer with registered pull outputs
module pcileech_ft245_word2byte
  import pcileech_ft245_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_word,
  input  logic              i_pop,
  output logic [BYTE_W-1:0] o_din,
  output logic              o_empty,
  output logic              o_wr_en,
  output logic [2:0]        o_bcnt
);
  logic [WORD_W-1:0] r_sreg;
  logic [BYTE_W-1:0] r_din;
  logic [2:0]        r_bcnt;
  logic              r_empty, r_wr_en, w_pop;
  assign w_pop   = i_pop & ~r_empty;
  assign o_din   = r_din;
  assign o_empty = r_empty;
  assign o_wr_en = r_wr_en;
  assign o_bcnt  = r_bcnt;
  // a load on the same edge as the final pop refills without an empty bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sreg  <= '0;
      r_din   <= '0;
      r_bcnt  <= '0;
      r_empty <= 1'b1;
      r_wr_en <= 1'b0;
    end else begin
      r_wr_en <= w_pop;
      if (w_pop) r_din <= r_sreg[BYTE_W-1:0];
      if (i_load) begin
        r_sreg  <= i_word;
        r_bcnt  <= 3'd4;
        r_empty <= 1'b0;
      end else if (w_pop) begin
        r_sreg  <= r_sreg >> BYTE_W;
        r_bcnt  <= r_bcnt - 3'd1;
        r_empty <= (r_bcnt == 3'd1);
      end
    end
  end
endmodule

// File: rtl/pcileech_ft245_tx_arb.sv
// pcileech_ft245_tx_arb: round-robin, burst-bounded arbiter of word sources onto the FT245 byte pull path
// PCILEECH_FT245_TX_ARB_HDR_EN: prefix every grant with header word {24'hE0A500, 5'b0, grant_id}
module pcileech_ft245_tx_arb
  import pcileech_ft245_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int MAX_BURST = 64
) (
  input logic clk,
  input logic rst,
  pcileech_ft245_tx_arb_if.master bus
);
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
`ifdef PCILEECH_FT245_TX_ARB_HDR_EN
  localparam state_t S_START = S_HDR;
`else
  localparam state_t S_START = S_GRANT;
`endif
  state_t            r_state;
  logic [2:0]        r_ptr, r_gnt;
  logic [7:0]        r_burst;
  logic [NUM_SRC-1:0] w_sel;
  logic              w_vld, w_last, w_rdy, w_acc, w_load, w_hi_found;
  logic [2:0]        w_lo, w_hi, w_next, w_bcnt;
  logic [WORD_W-1:0] w_src_word, w_word;
  assign w_sel          = NUM_SRC'(1) << r_gnt;
  assign w_vld          = |(bus.src_valid & w_sel);
  assign w_last         = |(bus.src_last & w_sel);
  assign w_rdy          = (r_state == S_GRANT) & ((w_bcnt == 3'd0) | ((w_bcnt == 3'd1) & bus.ft_din_req_data));
  assign w_acc          = w_rdy & w_vld;
  assign bus.src_ready  = w_rdy ? w_sel : '0;
  assign bus.grant_id   = r_gnt;
  assign w_next         = w_hi_found ? w_hi : w_lo;
  // lowest valid index at or above the pointer wins, else the lowest valid overall
  always_comb begin
    w_src_word = '0;
    w_lo       = '0;
    w_hi       = '0;
    w_hi_found = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_sel[i]) w_src_word = bus.src_data[i*WORD_W +: WORD_W];
      if (bus.src_valid[i]) w_lo = 3'(i);
      if (bus.src_valid[i] && i >= int'(r_ptr)) begin
        w_hi       = 3'(i);
        w_hi_found = 1'b1;
      end
    end
  end
`ifdef PCILEECH_FT245_TX_ARB_HDR_EN
  assign w_load = w_acc | (r_state == S_HDR);
  assign w_word = (r_state == S_HDR) ? {HDR_TAG, 5'b0, r_gnt} : w_src_word;
`else
  assign w_load = w_acc;
  assign w_word = w_src_word;
`endif
  pcileech_ft245_word2byte u_w2b (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_word  (w_word),
    .i_pop   (bus.ft_din_req_data),
    .o_din   (bus.ft_din),
    .o_empty (bus.ft_din_empty),
    .o_wr_en (bus.ft_din_wr_en),
    .o_bcnt  (w_bcnt)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_burst <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (|bus.src_valid) begin
          r_gnt   <= w_next;
          r_burst <= '0;
          r_state <= S_START;
        end
`ifdef PCILEECH_FT245_TX_ARB_HDR_EN
        S_HDR: r_state <= S_GRANT;
`endif
        S_GRANT: if (w_acc) begin
          r_burst <= r_burst + 8'd1;
          if (w_last || r_burst == BURST_LAST) r_state <= S_DRAIN;
        end else if (!w_vld && w_bcnt == 3'd0) r_state <= S_DRAIN;
        S_DRAIN: if (w_bcnt == 3'd0) begin
          r_ptr   <= (r_gnt == 3'(NUM_SRC - 1)) ? 3'd0 : r_gnt + 3'd1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
